cmp_sort_ctrl: RTL and testbench
================================

# cmp_sort_ctrl

Sequencing controller that sorts a block of N unsigned 8-bit words ascending by time-sharing one instance of the team's combinational 8-bit `compare` unit (`a`, `b` → `GREATER`, `LESS`). It accepts N words over a valid/ready input stream and bubble-sorts them in a local register array, one comparison per clock. It then streams them out over a valid/ready output. It sits between a producer of unsorted samples and any consumer needing ordered data, and exercises `compare` as a shared datapath resource.

## Interface
Parameters:
- `N`, 8: words per block; legal 2..16 (elaboration error otherwise).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: producer has a word on `in_data`.
- `in_ready`  out  1: controller accepts a word this cycle.
- `in_data`  in  8: unsigned input word.
- `out_valid`  out  1: `out_data` holds a sorted word.
- `out_ready`  in  1: consumer accepts `out_data` this cycle.
- `out_data`  out  8: sorted word, ascending order.
- `busy`  out  1: high in SORT state.
- `cmp_count`  out  16: comparisons issued during the last/current sort.

## Operation
- The FSM has three states: LOAD, SORT, DRAIN.
- LOAD:
  - `in_ready`=1.
  - On `in_valid&in_ready`, write `mem[wr_idx]`=`in_data`, then `wr_idx++`.
  - After the N-th accept, go to SORT next cycle. Clear `cmp_count`, pass index, `j` and `swapped`.
- SORT:
  - Each cycle, drive `compare.a`=`mem[j]` and `compare.b`=`mem[j+1]`.
  - If `GREATER`=1, swap the two entries at the clock edge and set `swapped`.
  - Equal words (`GREATER`=`LESS`=0) are never swapped, so the sort is stable.
  - `cmp_count++` every SORT cycle.
  - `j` runs 0..N-2; every pass is a full N-1 compares, with no shrinking window.
  - At the end of a pass (`j`=N-2):
    - If no swap occurred in the pass (including the current compare), or N-1 passes are complete, go to DRAIN.
    - Otherwise `j`=0, `pass++`, clear `swapped`.
- DRAIN:
  - `out_valid`=1, `out_data`=`mem[rd_idx]`.
  - On `out_valid&out_ready`, `rd_idx++`.
  - After the N-th transfer, return to LOAD with `wr_idx`=`rd_idx`=0.
- `LESS` is unused by the swap decision. It is routed to a lint-waived internal net.
- `cmp_count` holds its value through DRAIN and LOAD until the next SORT entry clears it.
- The `mem` array is not reset. Contents after reset are don't-care until reloaded.

## Timing
- Reset, when `rst`=1 at an edge:
  - state=LOAD; `wr_idx`, `rd_idx`, `j`, `pass`, `swapped`=0; `cmp_count`=0.
  - Outputs after that edge: `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=`mem[0]` (don't-care).
  - Reset in any state, including mid-SORT or mid-DRAIN, discards the block. No partial output follows.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to them.
- LOAD:
  - Takes at least N cycles.
  - `in_valid` gaps stall LOAD without penalty.
  - A word presented on the cycle the FSM leaves LOAD is not accepted (`in_ready`=0).
- SORT latency:
  - (N-1)·P cycles, where P is the number of passes (1..N-1).
  - Already-sorted input: N-1 cycles.
  - Worst case: (N-1)² cycles (49 for N=8).
- DRAIN:
  - The first `out_valid` appears the cycle after SORT exits.
  - One word per cycle while `out_ready`=1.
  - `out_data` is stable while `out_valid&!out_ready`.
- Handshakes: the input and output sides are never active in the same cycle.

## Structure
- Package `cmp_sort_pkg`:
  - `DATA_W`=8.
  - State typedef `sort_state_t` {LOAD, SORT, DRAIN}.
  - Index width function `clog2(N)`.
- One sub-module: the existing `compare`, instantiated once as `u_cmp`, with combinational mux selection of `mem[j]` and `mem[j+1]`.
- All other logic (FSM, counters, register array) lives in `cmp_sort_ctrl`.

## Test plan
All scenarios use N=8 unless stated.
- Ascending load 1..8 → SORT lasts 7 cycles; `cmp_count`=7; outputs 1,2,…,8.
- Descending load 8..1 → `cmp_count`=49; `busy` high for 49 cycles; outputs 1..8.
- Mixed with extremes and duplicates {0xFF,0x00,0x80,0x7F,0x80,0x01,0xFF,0x00} → outputs 00,00,01,7F,80,80,FF,FF. Equal words do not swap, checked via a probe of `u_cmp` and the `mem` swap enable.
- All words 0x55 → one pass, `cmp_count`=7, eight 0x55 outputs.
- Backpressure: `out_ready` toggles 1,0,0,1,… → no word lost or duplicated; `out_data` stable while stalled. `in_valid` gaps during LOAD are tolerated.
- `rst` pulsed at SORT cycle 10 of a descending block → next cycle state=LOAD, `in_ready`=1, `out_valid`=0, `cmp_count`=0. A fresh ascending block then sorts correctly.

Source files
------------

// File: rtl/cmp_sort_pkg.sv
// Shared types and helpers for the block sorter built around the 8-bit compare unit.
package cmp_sort_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } sort_state_t;

  // Index width for an N-entry array; never below 1 bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/compare.sv
// Team combinational magnitude comparator for unsigned 8-bit words.
module compare (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       GREATER,
  output logic       LESS
);

  assign GREATER = (a > b);
  assign LESS    = (a < b);

endmodule

// File: rtl/cmp_sort_ctrl.sv
// Loads N words, bubble-sorts them ascending with one shared compare per clock,
// then streams them out; input and output handshakes never overlap.
module cmp_sort_ctrl
  import cmp_sort_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [15:0]       cmp_count
);

  localparam int IDX_W = clog2(N);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] J_LAST    = IDX_W'(N - 2);
  localparam logic [IDX_W-1:0] PASS_LAST = IDX_W'(N - 2);

  generate
    if (N < 2 || N > 16) begin : g_bad_n
      $error("cmp_sort_ctrl: N must be in 2..16");
    end
  endgenerate

  sort_state_t       state, state_nxt;
  logic [IDX_W-1:0]  wr_idx, rd_idx, j, pass;
  logic [IDX_W-1:0]  j_p1;
  logic              swapped;
  logic [DATA_W-1:0] mem [N];

  logic [DATA_W-1:0] cmp_a, cmp_b;
  logic              cmp_gt;
  logic              cmp_less_unused;
  logic              mem_swap;
  logic              load_last, sort_exit, drain_last;

  // Shared comparator: operands are muxed from the adjacent pair at j.
  assign j_p1  = j + IDX_ONE;
  assign cmp_a = mem[j];
  assign cmp_b = mem[j_p1];

  compare u_cmp (
    .a       (cmp_a),
    .b       (cmp_b),
    .GREATER (cmp_gt),
    .LESS    (cmp_less_unused)
  );

  // Strictly-greater only, so equal words keep their order.
  assign mem_swap   = (state == SORT) && cmp_gt;
  assign load_last  = (state == LOAD) && in_valid && (wr_idx == IDX_LAST);
  assign sort_exit  = (j == J_LAST) && (!(swapped || cmp_gt) || (pass == PASS_LAST));
  assign drain_last = (state == DRAIN) && out_ready && (rd_idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (load_last) state_nxt = SORT;
      SORT:    if (sort_exit) state_nxt = DRAIN;
      DRAIN:   if (drain_last) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Handshake flags depend on registered state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      LOAD:    in_ready  = 1'b1;
      SORT:    busy      = 1'b1;
      DRAIN:   out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_data = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx    <= '0;
      rd_idx    <= '0;
      j         <= '0;
      pass      <= '0;
      swapped   <= 1'b0;
      cmp_count <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (in_valid) begin
            wr_idx <= load_last ? '0 : wr_idx + IDX_ONE;
            if (load_last) begin
              cmp_count <= '0;
              pass      <= '0;
              j         <= '0;
              swapped   <= 1'b0;
            end
          end
        end
        SORT: begin
          cmp_count <= cmp_count + 16'd1;
          if (j == J_LAST) begin
            j       <= '0;
            pass    <= pass + IDX_ONE;
            swapped <= 1'b0;
          end else begin
            j       <= j_p1;
            swapped <= swapped | cmp_gt;
          end
        end
        DRAIN: begin
          if (out_ready) rd_idx <= drain_last ? '0 : rd_idx + IDX_ONE;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; its contents only matter once a block
  // is loaded. Non-blocking writes let the two swap assignments read old values.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) begin
      mem[wr_idx] <= in_data;
    end else if (mem_swap) begin
      mem[j]    <= mem[j_p1];
      mem[j_p1] <= mem[j];
    end
  end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Directed bench for cmp_sort_ctrl (N=8): sort latency, ordering, stability,
// backpressure and mid-sort reset, with hand-computed expectations.
module tb_cmp_sort_ctrl;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        busy;
  logic [15:0] cmp_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cmp_sort_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .cmp_count (cmp_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge in LOAD; returns at the first SORT negedge with a junk
  // word still offered, which must not be accepted.
  task automatic load_block(input logic [7:0] v [N], input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps && (i % 3 == 1)) begin
        in_valid = 1'b0;
        @(negedge clk);
        check("load_gap_ready", in_ready, 1);
      end
      in_valid = 1'b1;
      in_data  = v[i];
      check("load_ready", in_ready, 1);
      @(negedge clk);
    end
    check("leave_load_ready", in_ready, 0);
    check("sort_busy", busy, 1);
    in_data = 8'hEE;
  endtask

  task automatic run_sort(input int stop_at, output int cycles);
    cycles = 0;
    while (busy && cycles < 300 && cycles != stop_at) begin
      if (dut.u_cmp.a == dut.u_cmp.b) begin
        check("eq_gt", dut.u_cmp.GREATER, 0);
        check("eq_noswap", dut.mem_swap, 0);
      end
      cycles++;
      @(negedge clk);
      in_valid = 1'b0;
    end
    if (cycles >= 300) check("sort_timeout", busy, 0);
  endtask

  task automatic drain(input logic [7:0] e [N], input bit bp, output int cycles);
    int n;
    bit stalled;
    logic [7:0] held;
    n = 0;
    stalled = 1'b0;
    held = 8'h00;
    cycles = 0;
    check("first_valid", out_valid, 1);
    while (n < N && cycles < 200) begin
      out_ready = bp ? (cycles % 3 == 0) : 1'b1;
      if (stalled && out_valid) check("stall_stable", out_data, held);
      if (out_valid && out_ready) begin
        check($sformatf("out%0d", n), out_data, e[n]);
        n++;
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      cycles++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    if (n < N) check("drain_timeout", n, N);
    check("back_in_ready", in_ready, 1);
    check("back_out_valid", out_valid, 0);
  endtask

  logic [7:0] asc  [N];
  logic [7:0] desc [N];
  logic [7:0] mix  [N];
  logic [7:0] mixs [N];
  logic [7:0] same [N];
  int cyc, dcyc;

  initial begin
    asc  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    desc = '{8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    mix  = '{8'hFF, 8'h00, 8'h80, 8'h7F, 8'h80, 8'h01, 8'hFF, 8'h00};
    mixs = '{8'h00, 8'h00, 8'h01, 8'h7F, 8'h80, 8'h80, 8'hFF, 8'hFF};
    same = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cmp_count", cmp_count, 0);

    // Already sorted: a single pass.
    load_block(asc, 1'b0);
    run_sort(-1, cyc);
    check("asc_sort_cycles", cyc, 7);
    check("asc_cmp_count", cmp_count, 7);
    drain(asc, 1'b0, dcyc);
    check("asc_drain_cycles", dcyc, 8);
    check("asc_cmp_hold", cmp_count, 7);

    // Worst case with output backpressure 1,0,0,...
    load_block(desc, 1'b0);
    run_sort(-1, cyc);
    check("desc_sort_cycles", cyc, 49);
    check("desc_cmp_count", cmp_count, 49);
    drain(asc, 1'b1, dcyc);

    // Extremes and duplicates, loaded with input gaps.
    load_block(mix, 1'b1);
    run_sort(-1, cyc);
    drain(mixs, 1'b0, dcyc);

    // All equal: no swaps, one pass.
    load_block(same, 1'b0);
    run_sort(-1, cyc);
    check("same_sort_cycles", cyc, 7);
    check("same_cmp_count", cmp_count, 7);
    drain(same, 1'b0, dcyc);

    // Reset in the middle of a worst-case sort discards the block.
    load_block(desc, 1'b0);
    run_sort(10, cyc);
    check("mid_sort_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmp_count", cmp_count, 0);
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_output", out_valid, 0);
    end
    load_block(asc, 1'b0);
    run_sort(-1, cyc);
    check("post_rst_sort_cycles", cyc, 7);
    drain(asc, 1'b0, dcyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
